// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite slave to APB master bridge with a parametrised slave count and a PREADY timeout.
// Decode misses, PSLVERR and timeouts all return a two-cycle AHB ERROR response.
module ahb_apb_bridge_param #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    HCLK,
  input  logic                    RESET,
  input  logic                    HSEL,
  input  logic [ADDR_W+SEL_W-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic                    HREADY,
  input  logic [DATA_W-1:0]       HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_W-1:0]       HRDATA,
  output logic [NUM_SLAVES-1:0]   PSEL,
  output logic [ADDR_W-1:0]       PADDR,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_W-1:0]       PWDATA,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SEL_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [DATA_W-1:0]   r_hrdata;
  logic [SEL_W-1:0]    w_idx_in;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_accept;
  logic                w_miss;
  logic                w_timeout;
  logic                w_sel_active;
  logic                w_unused;

  // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
  assign w_unused  = HTRANS[0];

  assign w_idx_in  = HADDR[ADDR_W+SEL_W-1:ADDR_W];
  assign w_accept  = HSEL & HREADY & HTRANS[1] & ((r_state == StIdle) | (r_state == StErr2));
  assign w_miss    = ({1'b0, w_idx_in} >= (SEL_W + 1)'(NUM_SLAVES));
  assign w_cnt_inc = r_cnt + 1'b1;
  // Fires on the last permitted wait cycle, so ACCESS lasts exactly TIMEOUT cycles.
  assign w_timeout = (TIMEOUT != 0) && !PREADY && (w_cnt_inc == CNT_W'(TIMEOUT));

  assign HRDATA = r_hrdata;
  assign PADDR  = r_paddr;
  assign PWRITE = r_pwrite;
  assign PWDATA = r_pwdata;

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    HREADYOUT    = 1'b1;
    HRESP        = 1'b0;
    PENABLE      = 1'b0;
    w_sel_active = 1'b0;
    unique case (r_state)
      StIdle, StErr2: begin
        HRESP = (r_state == StErr2);
        if (w_accept) begin
          if (w_miss) begin
            w_state_nxt = StErr1;
          end else if (HWRITE) begin
            w_state_nxt = StWdata;
          end else begin
            w_state_nxt = StSetup;
          end
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StWdata: begin
        HREADYOUT   = 1'b0;
        w_state_nxt = StSetup;
      end
      StSetup: begin
        HREADYOUT    = 1'b0;
        w_sel_active = 1'b1;
        w_state_nxt  = StAccess;
      end
      StAccess: begin
        HREADYOUT    = 1'b0;
        w_sel_active = 1'b1;
        PENABLE      = 1'b1;
        if (PREADY) begin
          w_state_nxt = PSLVERR ? StErr1 : StIdle;
        end else if (w_timeout) begin
          w_state_nxt = StErr1;
        end
      end
      StErr1: begin
        HREADYOUT   = 1'b0;
        HRESP       = 1'b1;
        w_state_nxt = StErr2;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_comb begin
    PSEL = '0;
    if (w_sel_active) begin
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
        PSEL[i] = (r_idx == SEL_W'(i));
      end
    end
  end

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_hrdata <= '0;
    end else begin
      if (w_accept) begin
        r_idx    <= w_idx_in;
        r_paddr  <= HADDR[ADDR_W-1:0];
        r_pwrite <= HWRITE;
      end
      if (r_state == StWdata) begin
        r_pwdata <= HWDATA;
      end
      if (w_state_nxt == StSetup) begin
        r_cnt <= '0;
      end else if ((r_state == StAccess) && !PREADY) begin
        r_cnt <= w_cnt_inc;
      end
      if ((r_state == StAccess) && PREADY && !PSLVERR && !r_pwrite) begin
        r_hrdata <= PRDATA;
      end
    end
  end

endmodule
